// File: rtl/ip_ft232h.sv
// FT232H 245 synchronous-FIFO mode model, wired as a byte loopback.
// Bytes written on adbus are queued and returned on the receive side in FIFO order.
module ip_ft232h #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  output logic       clkout,
  inout  wire  [7:0] adbus,
  output logic       txe_n,
  input  logic       wr_n,
  input  logic       siwu_n,
  output logic       rxf_n,
  input  logic       oe_n,
  input  logic       rd_n
);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          rd_drive;
  logic          siwu_unused;

  // Send-immediate/wake-up is reserved in this model.
  assign siwu_unused = siwu_n;

  assign clkout = clk;

  // Accept/consume qualifiers and next occupancy.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count;
    push       = !wr_n && !txe_n;
    pop        = !rd_n && !oe_n && !rxf_n;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  // The DUT only drives the bus while the user is not writing, avoiding contention.
  assign rd_drive = !oe_n && !rxf_n && wr_n;
  assign adbus    = rd_drive ? mem[rd_ptr] : 'z;

  // Pointer, occupancy and handshake-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      txe_n  <= 1'b1;
      rxf_n  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      txe_n <= (count_next == (AW+1)'(DEPTH));
      // Held high while the user is writing so the bus never has two drivers.
      rxf_n <= !((count_next != '0) && wr_n);
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= adbus;
  end

endmodule

// File: tb/tb_ip_ft232h.sv
// Scoreboard bench for the ip_ft232h loopback model.
module tb_ip_ft232h;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkout;
  wire  [7:0] adbus;
  logic       txe_n;
  logic       wr_n = 1'b1;
  logic       siwu_n = 1'b1;
  logic       rxf_n;
  logic       oe_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       drive_en = 1'b0;
  logic [7:0] tb_data = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int mcount = 0;
  logic [7:0] exp_q[$];

  assign adbus = drive_en ? tb_data : 'z;

  ip_ft232h #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clkout(clkout), .adbus(adbus), .txe_n(txe_n),
    .wr_n(wr_n), .siwu_n(siwu_n), .rxf_n(rxf_n), .oe_n(oe_n), .rd_n(rd_n)
  );

  always #5 clk = ~clk;

  // Monitor: a pop with the DUT driving the bus happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !oe_n && !rxf_n && !rd_n && wr_n) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: adbus=%02h, required no pop (queue empty)", adbus);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (adbus !== e) begin
          miscompares++;
          $display("FAIL readback: adbus=%02h, required %02h", adbus, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    drive_en = 1'b1;
    tb_data  = b;
    wr_n     = 1'b0;
    if (mcount < DEPTH) begin
      exp_q.push_back(b);
      mcount++;
    end
    tick();
  endtask

  task automatic end_write();
    wr_n     = 1'b1;
    drive_en = 1'b0;
    tick();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    oe_n = 1'b0;
    rd_n = 1'b0;
    while (rxf_n == 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_bound", {31'd0, rxf_n}, 32'd1);
    check("drain_empty", exp_q.size(), 0);
    mcount = 0;
    tick();
    tick();
    check("extra_rd_rxf", {31'd0, rxf_n}, 32'd1);
    check("extra_rd_txe", {31'd0, txe_n}, 32'd0);
    oe_n = 1'b1;
    rd_n = 1'b1;
  endtask

  logic [7:0] v2 [8]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11};
  logic [7:0] v3 [16] = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    // 1: reset and release
    #1;
    tick();
    tick();
    check("rst_txe", {31'd0, txe_n}, 32'd1);
    check("rst_rxf", {31'd0, rxf_n}, 32'd1);
    rst = 1'b0;
    tick();
    check("rel_txe", {31'd0, txe_n}, 32'd0);
    check("rel_rxf", {31'd0, rxf_n}, 32'd1);

    // 2: eight bytes, rxf_n held high while writing
    for (int unsigned i = 0; i < 8; i++) begin
      siwu_n = i[0];
      write_byte(v2[i]);
    end
    siwu_n = 1'b1;
    check("rxf_during_wr", {31'd0, rxf_n}, 32'd1);
    end_write();
    check("rxf_after_wr", {31'd0, rxf_n}, 32'd0);
    drain(12);

    // 3: sixteen bytes including a run of zeros
    for (int unsigned i = 0; i < 16; i++) write_byte(v3[i]);
    end_write();
    check("rxf_t3", {31'd0, rxf_n}, 32'd0);
    drain(20);

    // 4: overfill; pointers wrap past DEPTH-1
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      write_byte(8'(i * 3 + 7));
      check("txe_fill", {31'd0, txe_n}, {31'd0, (i + 1 >= DEPTH)});
    end
    end_write();
    check("txe_full", {31'd0, txe_n}, 32'd1);
    drain(DEPTH + 4);

    // 5: simultaneous push and pop keeps order
    write_byte(8'hA1);
    write_byte(8'hA2);
    write_byte(8'hA3);
    end_write();
    rd_n = 1'b0;
    oe_n = 1'b1;
    tick();
    check("rd_no_oe_rxf", {31'd0, rxf_n}, 32'd0);
    oe_n = 1'b0;
    tick();
    drive_en = 1'b1;
    tb_data  = 8'hA4;
    wr_n     = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hA4);
    tick();
    check("simul_rxf", {31'd0, rxf_n}, 32'd1);
    wr_n     = 1'b1;
    drive_en = 1'b0;
    rd_n     = 1'b1;
    oe_n     = 1'b1;
    tick();
    check("simul_rxf_back", {31'd0, rxf_n}, 32'd0);
    mcount = exp_q.size();
    check("simul_depth", mcount, 2);
    drain(8);

    // 6: reset mid-read discards queued data
    for (int unsigned i = 0; i < 5; i++) write_byte(8'(8'h50 + i));
    end_write();
    oe_n = 1'b0;
    rd_n = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    mcount = 0;
    check("midrst_rxf", {31'd0, rxf_n}, 32'd1);
    check("midrst_txe", {31'd0, txe_n}, 32'd1);
    rst = 1'b0;
    tick();
    check("post_rst_txe", {31'd0, txe_n}, 32'd0);
    tick();
    tick();
    check("post_rst_rxf", {31'd0, rxf_n}, 32'd1);
    oe_n = 1'b1;
    rd_n = 1'b1;

    // Flow still works after the reset
    write_byte(8'h5A);
    end_write();
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
